// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   DATA_BITS                  payload bits per frame (fixed at 8)
//   IDX_W                      width of the data bit index
//   LINE_IDLE / START_LEVEL / STOP_LEVEL   serial line levels
//   tx_state_t                 transmitter FSM state encoding
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and raises bit_strobe during the
// last cycle of each bit period, then wraps to 0.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   enable     count while high
//   clear      force the count to 0 (takes priority over enable)
//   bit_strobe high in the final cycle of a bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic bit_strobe
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

    // Internal strobe only; every block output that uses it is registered.
    assign bit_strobe = enable && (count == LAST);

endmodule

// File: rtl/uart_tx_block.sv
// 8N1 UART transmitter with a one-byte holding register ahead of the
// shift register, so the next byte can be queued while a frame is on the
// wire. Consecutive frames are sent with no idle gap between them.
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset; aborts any frame
//   tx_data        byte to send, sampled only when tx_load=1
//   tx_load        single-cycle write strobe
//   overrun_clear  clears overrun_error (a same-edge overrun wins)
//   serial_out     UART line, idle high
//   tx_busy        high during start, data and stop bits
//   buffer_full    holding register occupied
//   tx_done        one-cycle pulse at the end of each stop bit
//   overrun_error  sticky: a write was dropped because the buffer was full
import uart_pkg::*;

module uart_tx_block #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_load,
    input  logic                 overrun_clear,
    output logic                 serial_out,
    output logic                 tx_busy,
    output logic                 buffer_full,
    output logic                 tx_done,
    output logic                 overrun_error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state, state_d;
    logic [DATA_BITS-1:0] hold;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [IDX_W-1:0]     bit_idx, bit_idx_d;
    logic                 bit_strobe;
    logic                 transfer;
    logic                 load_accept;
    logic                 overrun_set;
    logic                 line_d;
    logic                 busy_d;
    logic                 done_d;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (state != IDLE),
        .clear      (state == IDLE),
        .bit_strobe (bit_strobe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus the next values of the registered line/busy/done
    // outputs, so the line changes on the same edge as the state.
    always_comb begin
        state_d   = state;
        shift_d   = shift;
        bit_idx_d = bit_idx;
        transfer  = 1'b0;
        done_d    = 1'b0;

        case (state)
            IDLE: begin
                if (buffer_full) begin
                    transfer = 1'b1;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_strobe) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_strobe) begin
                    if (bit_idx == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift >> 1;
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (bit_strobe) begin
                    done_d = 1'b1;
                    // Chain straight into the next start bit when a byte waits.
                    if (buffer_full) begin
                        transfer = 1'b1;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (transfer) begin
            shift_d = hold;
        end

        case (state_d)
            START:   line_d = START_LEVEL;
            DATA:    line_d = shift_d[0];
            STOP:    line_d = STOP_LEVEL;
            default: line_d = LINE_IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // A write into a full buffer is only accepted when the held byte moves
    // to the shifter on that same edge.
    assign load_accept = tx_load && (!buffer_full || transfer);
    assign overrun_set = tx_load && buffer_full && !transfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold          <= '0;
            shift         <= '0;
            bit_idx       <= '0;
            buffer_full   <= 1'b0;
            overrun_error <= 1'b0;
            serial_out    <= LINE_IDLE;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            shift      <= shift_d;
            bit_idx    <= bit_idx_d;
            serial_out <= line_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;

            if (load_accept) begin
                hold        <= tx_data;
                buffer_full <= 1'b1;
            end else if (transfer) begin
                buffer_full <= 1'b0;
            end

            if (overrun_set) begin
                overrun_error <= 1'b1;
            end else if (overrun_clear) begin
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Self-checking bench for uart_tx_block. Two instances share stimulus:
// CLKS_PER_BIT=10 for directed timing checks, CLKS_PER_BIT=2 for a random
// byte stream. A frame-scheduling reference model predicts accepted bytes
// and flags; a line monitor decodes 8N1 frames and pops expected bytes.
module tb_uart_tx_block;

    localparam int CPB_A = 10;
    localparam int CPB_B = 2;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic [7:0] tx_data       = 8'h00;
    logic       tx_load       = 1'b0;
    logic       overrun_clear = 1'b0;
    logic       sel           = 1'b0;
    logic       phase6        = 1'b0;

    logic so_a, busy_a, full_a, done_a, ovr_a;
    logic so_b, busy_b, full_b, done_b, ovr_b;
    logic m_so, m_busy, m_full, m_done, m_ovr;
    int   mon_cpb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_block #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load),
        .overrun_clear(overrun_clear), .serial_out(so_a), .tx_busy(busy_a),
        .buffer_full(full_a), .tx_done(done_a), .overrun_error(ovr_a)
    );

    uart_tx_block #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load),
        .overrun_clear(overrun_clear), .serial_out(so_b), .tx_busy(busy_b),
        .buffer_full(full_b), .tx_done(done_b), .overrun_error(ovr_b)
    );

    assign m_so    = sel ? so_b   : so_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_full  = sel ? full_b : full_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_ovr   = sel ? ovr_b  : ovr_a;
    assign mon_cpb = sel ? CPB_B  : CPB_A;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame scheduling ----------------
    // A byte starts on the first edge where one is held, the line is free
    // (previous frame's end edge reached) and it was captured earlier.
    // Each frame takes 10 bit periods.
    logic [7:0] exp_q[$];
    longint ecount    = 0;
    longint frame_end = 0;
    longint held_edge = 0;
    bit     held      = 0;
    bit     e_busy = 0, e_full = 0, e_done = 0, e_ovr = 0;
    int     drops     = 0;
    int     ovr_cycles = 0;
    int     rst_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        bit xfer;
        if (rst) begin
            held = 0; held_edge = 0; frame_end = 0;
            e_busy = 0; e_full = 0; e_done = 0; e_ovr = 0;
            drops = 0;
            exp_q.delete();
        end else begin
            ecount++;
            e_done = (ecount == frame_end);
            xfer = held && (ecount >= frame_end) && (ecount > held_edge);
            if (xfer) begin
                held = 0;
                frame_end = ecount + 10 * mon_cpb;
            end
            if (tx_load) begin
                if (!held) begin
                    held = 1;
                    held_edge = ecount;
                    exp_q.push_back(tx_data);
                end else begin
                    drops++;
                    e_ovr = 1;
                end
            end
            if (!(tx_load && !xfer && held && held_edge != ecount) && overrun_clear && !(tx_load && held && held_edge != ecount))
                e_ovr = 0;
            e_full = held;
            e_busy = (ecount < frame_end);
        end
    end

    always @(posedge rst) rst_cnt++;

    // ---------------- per-cycle flag checker ----------------
    always @(negedge clk) begin
        chk("tx_busy", m_busy, e_busy);
        chk("buffer_full", m_full, e_full);
        chk("tx_done", m_done, e_done);
        chk("overrun_error", m_ovr, e_ovr);
        if (phase6 && m_ovr) ovr_cycles++;
    end

    // ---------------- line monitor: 8N1 receiver ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && m_so == 1'b0) begin
                int   cpb;
                int   snap;
                bit   start_ok;
                bit   stop_ok;
                logic [7:0] b;
                cpb  = mon_cpb;
                snap = rst_cnt;
                repeat (cpb / 2) @(negedge clk);
                start_ok = (m_so == 1'b0);
                for (int k = 0; k < 8; k++) begin
                    repeat (cpb) @(negedge clk);
                    b[k] = m_so;
                end
                repeat (cpb) @(negedge clk);
                stop_ok = (m_so == 1'b1);
                if (snap == rst_cnt) begin
                    chk("framing", int'(start_ok && stop_ok), 1);
                    chk("rx_expected_pending", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) chk("rx_byte", b, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        tick();
        tx_load = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_busy || m_full) && n < 1000) begin
            tick();
            n++;
        end
        chk({name, "_idle_in_time"}, int'(n < 1000), 1);
        repeat (3) tick();
    endtask

    function automatic int exp_line(input int k, input logic [7:0] b);
        if (k <= 10) return 0;
        if (k <= 90) return (b >> ((k - 11) / 10)) & 1;
        return 1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) tick();
        chk("rst_serial_out", m_so, 1);
        chk("rst_busy", m_busy, 0);
        chk("rst_full", m_full, 0);
        chk("rst_done", m_done, 0);
        chk("rst_ovr", m_ovr, 0);
        rst = 1'b0;
        repeat (2) tick();

        // 1: single frame 0xA5, exact per-cycle line timing
        load(8'hA5);
        chk("t1_full_after_load", m_full, 1);
        for (int k = 1; k <= 101; k++) begin
            tick();
            chk("t1_line", m_so, exp_line(k, 8'hA5));
            if (k == 1)   chk("t1_full_cleared", m_full, 0);
            if (k == 100) begin chk("t1_done_e100", m_done, 0); chk("t1_busy_e100", m_busy, 1); end
            if (k == 101) begin chk("t1_done_e101", m_done, 1); chk("t1_busy_e101", m_busy, 0); end
        end
        wait_idle("t1");

        // 2: queued second byte, back-to-back frames
        load(8'h3C);
        repeat (30) tick();
        load(8'hC3);
        repeat (69) tick();
        chk("t2_full_e100", m_full, 1);
        chk("t2_stop_e100", m_so, 1);
        tick();
        chk("t2_full_e101", m_full, 0);
        chk("t2_start_e101", m_so, 0);
        chk("t2_busy_e101", m_busy, 1);
        chk("t2_done_e101", m_done, 1);
        repeat (100) tick();
        chk("t2_done_e201", m_done, 1);
        chk("t2_busy_e201", m_busy, 0);
        chk("t2_ovr", m_ovr, 0);
        wait_idle("t2");

        // 3: overrun, clear/set collision, clear
        load(8'h11);
        repeat (20) tick();
        load(8'h22);
        repeat (10) tick();
        load(8'h33);
        chk("t3_ovr_set", m_ovr, 1);
        chk("t3_full", m_full, 1);
        wait_idle("t3a");
        load(8'h44);
        load(8'h55);
        overrun_clear = 1'b1;
        load(8'h66);
        overrun_clear = 1'b0;
        chk("t3_set_wins", m_ovr, 1);
        overrun_clear = 1'b1;
        tick();
        overrun_clear = 1'b0;
        chk("t3_cleared", m_ovr, 0);
        wait_idle("t3b");

        // 4: load exactly at the STOP-to-START transfer edge
        load(8'h5A);
        repeat (20) tick();
        load(8'h6B);
        repeat (79) tick();
        load(8'h7C);
        chk("t4_full", m_full, 1);
        chk("t4_no_ovr", m_ovr, 0);
        chk("t4_start", m_so, 0);
        wait_idle("t4");

        // 5: asynchronous reset mid-frame, then a clean frame
        load(8'hFF);
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_line_high", m_so, 1);
        chk("t5_busy", m_busy, 0);
        chk("t5_full", m_full, 0);
        chk("t5_done", m_done, 0);
        chk("t5_ovr", m_ovr, 0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (120) tick();
        load(8'h00);
        wait_idle("t5");

        // 6: random stream on the CLKS_PER_BIT=2 instance
        rst = 1'b1;
        sel = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        overrun_clear = 1'b1;
        phase6 = 1'b1;
        tick();
        for (int i = 0; i < 200; i++) begin
            load(8'($urandom));
            repeat ($urandom_range(0, 25)) tick();
        end
        wait_idle("t6");
        repeat (5) tick();
        phase6 = 1'b0;
        chk("t6_overrun_count", ovr_cycles, drops);
        chk("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
